// File: rtl/distortion_pkg.sv
// distortion_pkg: shared types and the dry/wet crossfade arithmetic for the distortion controller
package distortion_pkg;
  localparam int SAMPLE_W = 32;
  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef enum logic [2:0] {BYPASS, FADE_IN, ACTIVE, FADE_OUT, SWAP} ctrl_state_t;
  // dry + ((wet - dry) * gain) >>> sh; the result always lies between dry and wet
  function automatic sample_t mix(sample_t dry, sample_t wet, logic [16:0] gain, int unsigned sh);
    logic signed [63:0] diff, prod, sum;
    diff = 64'(wet) - 64'(dry);
    prod = diff * $signed({47'd0, gain});
    sum = 64'(dry) + (prod >>> sh);
    return sum[SAMPLE_W-1:0];
  endfunction
endpackage

// File: rtl/switch_debounce.sv
// switch_debounce: accepts a raw switch change only after DEBOUNCE_SAMPLES consecutive differing strobes
module switch_debounce #(
  parameter int DEBOUNCE_SAMPLES = 64
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic sample_valid,
  input  logic raw,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_SAMPLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d;
  always_comb begin
    cnt_d = cnt_q;
    level_d = level_q;
    if (sample_valid) begin
      cnt_d = raw != level_q ? cnt_q + CW'(1) : '0;
      if (cnt_d == CW'(DEBOUNCE_SAMPLES)) begin
        level_d = raw;
        cnt_d = '0;
      end
    end
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt_q <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      level_q <= level_d;
    end
  end
  // post-update value, so the strobe that flips the level is seen by the sequencer on that same strobe
  assign level = level_d;
endmodule

// File: rtl/distortion_ctrl.sv
// distortion_ctrl: debounced enable/drive sequencing with click-free dry/wet crossfade
module distortion_ctrl
  import distortion_pkg::*;
#(
  parameter int FADE_LOG2 = 8,
  parameter int DEBOUNCE_SAMPLES = 64
) (
  input  logic    CLOCK_50,
  input  logic    reset,
  input  logic    sample_valid,
  input  logic    enable_req,
  input  logic    high_req,
  input  sample_t dry_L,
  input  sample_t dry_R,
  input  sample_t wet_L,
  input  sample_t wet_R,
  output logic    dist_enable,
  output logic    dist_high,
  output sample_t out_L,
  output sample_t out_R,
  output logic    out_valid,
  output logic    busy
);
  localparam logic [FADE_LOG2:0] G = {1'b1, {FADE_LOG2{1'b0}}};
  ctrl_state_t state_q, state_d;
  logic [FADE_LOG2:0] gain_q, gain_d, gain_dec;
  logic high_q, high_d, en_q, busy_q, ov_q, en_db, hi_db;
  sample_t out_l_q, out_r_q;
  switch_debounce #(.DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_en_db (
    .CLOCK_50(CLOCK_50), .reset(reset), .sample_valid(sample_valid), .raw(enable_req), .level(en_db)
  );
  switch_debounce #(.DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_hi_db (
    .CLOCK_50(CLOCK_50), .reset(reset), .sample_valid(sample_valid), .raw(high_req), .level(hi_db)
  );
  assign gain_dec = gain_q == '0 ? '0 : gain_q - 1'b1;
  always_comb begin
    state_d = state_q;
    gain_d = gain_q;
    high_d = high_q;
    if (sample_valid) begin
      case (state_q)
        BYPASS: begin
          gain_d = '0;
          if (en_db) begin
            high_d = hi_db;
            state_d = FADE_IN;
          end
        end
        FADE_IN: begin
          gain_d = gain_q == G ? G : gain_q + 1'b1;
          state_d = !en_db ? FADE_OUT : hi_db != high_q ? SWAP : gain_d == G ? ACTIVE : FADE_IN;
        end
        ACTIVE: begin
          gain_d = G;
          state_d = !en_db ? FADE_OUT : hi_db != high_q ? SWAP : ACTIVE;
        end
        FADE_OUT: begin
          gain_d = gain_dec;
          state_d = en_db && hi_db == high_q ? FADE_IN : gain_d == '0 ? BYPASS : FADE_OUT;
        end
        SWAP: begin
          gain_d = gain_dec;
          if (gain_d == '0) begin
            high_d = hi_db;
            state_d = en_db ? FADE_IN : BYPASS;
          end
        end
        default: begin
          state_d = BYPASS;
          gain_d = '0;
        end
      endcase
    end
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= BYPASS;
      gain_q <= '0;
      high_q <= 1'b0;
      en_q <= 1'b0;
      busy_q <= 1'b0;
      ov_q <= 1'b0;
      out_l_q <= '0;
      out_r_q <= '0;
    end else begin
      state_q <= state_d;
      gain_q <= gain_d;
      high_q <= high_d;
      en_q <= state_d != BYPASS;
      busy_q <= state_d inside {FADE_IN, FADE_OUT, SWAP};
      ov_q <= sample_valid;
      if (sample_valid) begin
        out_l_q <= mix(dry_L, wet_L, 17'(gain_q), FADE_LOG2);
        out_r_q <= mix(dry_R, wet_R, 17'(gain_q), FADE_LOG2);
      end
    end
  end
  assign dist_enable = en_q;
  assign dist_high = high_q;
  assign busy = busy_q;
  assign out_valid = ov_q;
  assign out_L = out_l_q;
  assign out_R = out_r_q;
endmodule

// File: tb/tb_distortion_ctrl.sv
// tb_distortion_ctrl: randomized and directed checks against a behavioural crossfade/sequencer model
module tb_distortion_ctrl;
  localparam int LOG2 = 2, DB = 2, G = 4;
  localparam int M_BYP = 0, M_IN = 1, M_ACT = 2, M_OUT = 3, M_SWP = 4;
  logic clk = 1'b0, rst, sv, en_r, hi_r;
  logic [31:0] dl, dr, wl, wr;
  logic [31:0] out_L, out_R;
  logic dist_enable, dist_high, out_valid, busy;
  int n_cmp = 0, n_bad = 0;
  int m_mode, m_g;
  int m_cnt [2];
  bit m_lvl [2];
  bit m_dh, m_de, m_ov, m_busy;
  logic [31:0] m_ol, m_or;
  always #5 clk = ~clk;
  distortion_ctrl #(.FADE_LOG2(LOG2), .DEBOUNCE_SAMPLES(DB)) dut (
    .CLOCK_50(clk), .reset(rst), .sample_valid(sv), .enable_req(en_r), .high_req(hi_r),
    .dry_L(dl), .dry_R(dr), .wet_L(wl), .wet_R(wr),
    .dist_enable(dist_enable), .dist_high(dist_high), .out_L(out_L), .out_R(out_R),
    .out_valid(out_valid), .busy(busy)
  );
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_mix(int dry, int wet, int g);
    longint d = longint'(wet) - longint'(dry);
    return 32'(longint'(dry) + ((d * g) >>> LOG2));
  endfunction
  task automatic model_clk();
    bit raw [2];
    bit en, hi;
    if (rst) begin
      m_mode = M_BYP; m_g = 0; m_cnt = '{0, 0}; m_lvl = '{0, 0};
      m_dh = 0; m_de = 0; m_ov = 0; m_busy = 0; m_ol = 0; m_or = 0;
      return;
    end
    m_ov = sv;
    if (!sv) return;
    m_ol = ref_mix(dl, wl, m_g);
    m_or = ref_mix(dr, wr, m_g);
    raw = '{en_r, hi_r};
    for (int k = 0; k < 2; k++) begin
      if (raw[k] != m_lvl[k]) begin
        m_cnt[k]++;
        if (m_cnt[k] == DB) begin m_lvl[k] = raw[k]; m_cnt[k] = 0; end
      end else m_cnt[k] = 0;
    end
    en = m_lvl[0];
    hi = m_lvl[1];
    case (m_mode)
      M_BYP: if (en) begin m_dh = hi; m_mode = M_IN; end
      M_IN: begin
        m_g++;
        if (!en) m_mode = M_OUT;
        else if (hi != m_dh) m_mode = M_SWP;
        else if (m_g == G) m_mode = M_ACT;
      end
      M_ACT: if (!en) m_mode = M_OUT; else if (hi != m_dh) m_mode = M_SWP;
      M_OUT: begin
        m_g--;
        if (en && hi == m_dh) m_mode = M_IN;
        else if (m_g == 0) m_mode = M_BYP;
      end
      default: begin
        m_g--;
        if (m_g == 0) begin m_dh = hi; m_mode = en ? M_IN : M_BYP; end
      end
    endcase
    m_de = m_mode != M_BYP;
    m_busy = m_mode == M_IN || m_mode == M_OUT || m_mode == M_SWP;
  endtask
  task automatic cyc(bit s);
    @(negedge clk);
    sv = s;
    @(posedge clk);
    model_clk();
    #1;
    chk("out_L", out_L, m_ol);
    chk("out_R", out_R, m_or);
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("dist_enable", 32'(dist_enable), 32'(m_de));
    chk("dist_high", 32'(dist_high), 32'(m_dh));
    chk("busy", 32'(busy), 32'(m_busy));
  endtask
  task automatic strobe(int gap);
    cyc(1);
    repeat (gap) cyc(0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] eng_exp [7];
    logic [31:0] byp_dry;
    int lim;
    eng_exp = '{32'd1000, 32'd1000, 32'd1000, 32'd850, 32'd700, 32'd550, 32'd400};
    rst = 1; sv = 0; en_r = 0; hi_r = 0; dl = 0; dr = 0; wl = 0; wr = 0;
    cyc(0); cyc(0);
    chk("rst_out_L", out_L, 32'd0);
    chk("rst_dist_enable", 32'(dist_enable), 32'd0);
    rst = 0;
    cyc(0);
    en_r = 1; dl = 1000; wl = 400; dr = 32'hFFFF_FC18; wr = 32'd77;
    for (int i = 0; i < 7; i++) begin
      strobe(3);
      chk("engage_seq", out_L, eng_exp[i]);
    end
    chk("engage_active_busy", 32'(busy), 32'd0);
    dl = 32'h8000_0000; wl = 32'h7FFF_FFFF;
    strobe(3);
    chk("endpoint_wet", out_L, 32'h7FFF_FFFF);
    hi_r = 1; dl = $urandom; wl = $urandom;
    lim = 0;
    do begin strobe(3); lim++; end while (!(m_mode == M_ACT && m_dh) && lim < 20);
    chk("swap_done_high", 32'(dist_high), 32'd1);
    chk("swap_done_enable", 32'(dist_enable), 32'd1);
    en_r = 0; dl = -1000; wl = -401;
    lim = 0;
    do begin strobe(3); lim++; end while (m_mode != M_BYP && lim < 20);
    byp_dry = $urandom; dr = byp_dry; wr = $urandom;
    strobe(3);
    chk("bypass_out_R", out_R, byp_dry);
    en_r = 1; strobe(3);
    en_r = 0; strobe(3); strobe(3);
    chk("glitch_enable", 32'(dist_enable), 32'd0);
    en_r = 1; hi_r = 1;
    lim = 0;
    do begin strobe(3); lim++; end while (m_g != 3 && lim < 20);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1; cyc(0);
    chk("mid_reset_out_L", out_L, 32'd0);
    chk("mid_reset_enable", 32'(dist_enable), 32'd0);
    rst = 0;
    strobe(3); strobe(3);
    chk("reengage_enable", 32'(dist_enable), 32'd1);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) en_r = ~en_r;
      if ($urandom_range(0, 7) == 0) hi_r = ~hi_r;
      dl = $urandom; dr = $urandom; wl = $urandom; wr = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        dl = {1'b0, dl[30:0]} >> $urandom_range(0, 20);
        wl = -dl;
      end
      rst = $urandom_range(0, 199) == 0;
      strobe($urandom_range(0, 3));
      rst = 0;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
